// File: rtl/formant_segment_dp.sv
// Min-cost spectral segmentation DP with runtime segment count, traceback and boundary stream.
module formant_segment_dp #(
   parameter int unsigned BIT_WIDTH = 32,
   parameter int unsigned I         = 160,
   parameter int unsigned MAX_SEG   = 8,
   parameter int unsigned E_LAT     = 2,
   localparam int unsigned I_WIDTH  = $clog2(I),
   localparam int unsigned K_WIDTH  = $clog2(MAX_SEG + 1)
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 start_in,
   input  logic [K_WIDTH-1:0]   num_seg_in,
   output logic                 e_req_valid,
   output logic [I_WIDTH-1:0]   e_req_j,
   output logic [I_WIDTH-1:0]   e_req_i,
   input  logic [BIT_WIDTH-1:0] e_resp_data,
   output logic                 busy,
   output logic                 bound_valid,
   input  logic                 bound_ready,
   output logic [I_WIDTH-1:0]   bound_data,
   output logic                 bound_last,
   output logic [BIT_WIDTH-1:0] cost_out,
   output logic                 done
);

   localparam int unsigned SEL_W = (MAX_SEG > 1) ? $clog2(MAX_SEG) : 1;
   localparam int unsigned CNT_W = $clog2(E_LAT + 1);
   localparam logic [BIT_WIDTH-1:0] ONES = '1;

   typedef enum logic [2:0] {StIdle, StFill, StDrain, StWrite, StTrace, StOut} state_e;

   state_e               state_q, state_d;
   logic                 busy_q, busy_d, done_q, done_d;
   logic [K_WIDTH-1:0]   k_q, k_d, tk_q, tk_d, idx_q, idx_d;
   logic                 req_v_q, req_v_d;
   logic [I_WIDTH-1:0]   req_j_q, req_j_d, req_i_q, req_i_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 ph_q, ph_d;
   logic [I_WIDTH-1:0]   tb_q, tb_d;
   logic                 bv_q, bv_d, bl_q, bl_d;
   logic [I_WIDTH-1:0]   bd_q, bd_d;
   logic [BIT_WIDTH-1:0] cost_q, cost_d;
   logic                 pv_q [E_LAT];
   logic                 pv_d [E_LAT];
   logic [I_WIDTH-1:0]   pj_q [E_LAT];
   logic [I_WIDTH-1:0]   pj_d [E_LAT];
   logic [BIT_WIDTH-1:0] min_q [MAX_SEG];
   logic [BIT_WIDTH-1:0] min_d [MAX_SEG];
   logic [I_WIDTH-1:0]   arg_q [MAX_SEG];
   logic [I_WIDTH-1:0]   arg_d [MAX_SEG];
   logic [I_WIDTH-1:0]   bnd_q [MAX_SEG];
   logic [I_WIDTH-1:0]   bnd_d [MAX_SEG];

   // Per-k RAMs (index k-1) and their shared-address read registers
   logic [BIT_WIDTH-1:0] f_mem [MAX_SEG][I];
   logic [I_WIDTH-1:0]   b_mem [MAX_SEG][I];
   logic [BIT_WIDTH-1:0] rd_f_q [MAX_SEG];
   logic [I_WIDTH-1:0]   rd_b_q [MAX_SEG];

   logic                 stg_v [E_LAT+1];
   logic [I_WIDTH-1:0]   stg_j [E_LAT+1];
   logic                 resp_v;
   logic [I_WIDTH-1:0]   resp_j, rd_addr, cand_arg;
   logic [BIT_WIDTH-1:0] cand [MAX_SEG];
   logic                 cand_ok [MAX_SEG];
   logic [SEL_W-1:0]     k_sel, tk_sel, tk_sel2, idx_sel, idx_nxt_sel;

   function automatic logic [BIT_WIDTH-1:0] sat_add(input logic [BIT_WIDTH-1:0] a,
                                                    input logic [BIT_WIDTH-1:0] b);
      logic [BIT_WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (a == ONES || b == ONES || sum[BIT_WIDTH]) return ONES;
      return sum[BIT_WIDTH-1:0];
   endfunction

   // Request pipeline: stage 0 is the live request, stage E_LAT lines up with its response
   always_comb begin
      stg_v[0] = req_v_q;
      stg_j[0] = req_j_q;
      for (int n = 1; n <= E_LAT; n++) begin
         stg_v[n] = pv_q[n-1];
         stg_j[n] = pj_q[n-1];
      end
      for (int n = 0; n < E_LAT; n++) begin
         pv_d[n] = stg_v[n];
         pj_d[n] = stg_j[n];
      end
      resp_v = stg_v[E_LAT];
      resp_j = stg_j[E_LAT];
      // F(k-1, j-1) is read one cycle ahead so it arrives together with E(j, i)
      if (state_q == StTrace) rd_addr = tb_q;
      else if (stg_j[E_LAT-1] == '0) rd_addr = '0;
      else rd_addr = stg_j[E_LAT-1] - I_WIDTH'(1);
   end

   // Candidate cost per k for the response in flight
   always_comb begin
      cand_arg   = resp_j - I_WIDTH'(1);
      cand[0]    = e_resp_data;
      cand_ok[0] = resp_v && (resp_j == '0);
      for (int m = 1; m < MAX_SEG; m++) begin
         cand[m]    = sat_add(rd_f_q[m-1], e_resp_data);
         cand_ok[m] = resp_v && (resp_j >= I_WIDTH'(m));
      end
      k_sel       = SEL_W'(k_q - K_WIDTH'(1));
      tk_sel      = SEL_W'(tk_q - K_WIDTH'(1));
      tk_sel2     = SEL_W'(tk_q - K_WIDTH'(2));
      idx_sel     = SEL_W'(idx_q - K_WIDTH'(1));
      idx_nxt_sel = SEL_W'(idx_q);
   end

   // Next-state: FSM sequencing, running min/argmin, traceback and output beats
   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      k_d     = k_q;
      req_v_d = req_v_q;
      req_j_d = req_j_q;
      req_i_d = req_i_q;
      cnt_d   = cnt_q;
      ph_d    = ph_q;
      tk_d    = tk_q;
      tb_d    = tb_q;
      bnd_d   = bnd_q;
      idx_d   = idx_q;
      bv_d    = bv_q;
      bd_d    = bd_q;
      bl_d    = bl_q;
      cost_d  = cost_q;
      min_d   = min_q;
      arg_d   = arg_q;
      // Strict less-than keeps the smallest j on ties
      for (int m = 0; m < MAX_SEG; m++) begin
         if (cand_ok[m] && (cand[m] < min_q[m])) begin
            min_d[m] = cand[m];
            arg_d[m] = cand_arg;
         end
      end
      case (state_q)
         StIdle: begin
            if (start_in) begin
               state_d = StFill;
               busy_d  = 1'b1;
               if (num_seg_in == '0) k_d = K_WIDTH'(1);
               else if (num_seg_in > K_WIDTH'(MAX_SEG)) k_d = K_WIDTH'(MAX_SEG);
               else k_d = num_seg_in;
               req_v_d = 1'b1;
               req_j_d = '0;
               req_i_d = '0;
               min_d   = '{default: ONES};
               arg_d   = '{default: '0};
            end
         end
         StFill: begin
            if (req_j_q == req_i_q) begin
               req_v_d = 1'b0;
               cnt_d   = '0;
               state_d = StDrain;
            end else begin
               req_j_d = req_j_q + I_WIDTH'(1);
            end
         end
         StDrain: begin
            if (cnt_q == CNT_W'(E_LAT)) state_d = StWrite;
            else cnt_d = cnt_q + CNT_W'(1);
         end
         StWrite: begin
            min_d = '{default: ONES};
            arg_d = '{default: '0};
            if (req_i_q == I_WIDTH'(I - 1)) begin
               state_d        = StTrace;
               ph_d           = 1'b0;
               tk_d           = k_q;
               tb_d           = I_WIDTH'(I - 1);
               bnd_d[k_sel]   = I_WIDTH'(I - 1);
            end else begin
               state_d = StFill;
               req_i_d = req_i_q + I_WIDTH'(1);
               req_j_d = '0;
               req_v_d = 1'b1;
            end
         end
         StTrace: begin
            if (!ph_q) begin
               ph_d = 1'b1;
            end else begin
               ph_d = 1'b0;
               if (tk_q == k_q) cost_d = rd_f_q[k_sel];
               if (tk_q <= K_WIDTH'(1)) begin
                  state_d = StOut;
                  idx_d   = K_WIDTH'(1);
               end else begin
                  bnd_d[tk_sel2] = rd_b_q[tk_sel];
                  tb_d           = rd_b_q[tk_sel];
                  tk_d           = tk_q - K_WIDTH'(1);
                  if (tk_q == K_WIDTH'(2)) begin
                     state_d = StOut;
                     idx_d   = K_WIDTH'(1);
                  end
               end
            end
         end
         StOut: begin
            if (!bv_q) begin
               bv_d = 1'b1;
               bd_d = bnd_q[idx_sel];
               bl_d = (idx_q == k_q);
            end else if (bound_ready) begin
               if (bl_q) begin
                  bv_d    = 1'b0;
                  bl_d    = 1'b0;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end else begin
                  idx_d = idx_q + K_WIDTH'(1);
                  bd_d  = bnd_q[idx_nxt_sel];
                  bl_d  = ((idx_q + K_WIDTH'(1)) == k_q);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset; reset drops in-flight responses
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         k_q     <= K_WIDTH'(1);
         req_v_q <= 1'b0;
         req_j_q <= '0;
         req_i_q <= '0;
         cnt_q   <= '0;
         ph_q    <= 1'b0;
         tk_q    <= '0;
         tb_q    <= '0;
         idx_q   <= '0;
         bv_q    <= 1'b0;
         bd_q    <= '0;
         bl_q    <= 1'b0;
         cost_q  <= '0;
         pv_q    <= '{default: 1'b0};
         pj_q    <= '{default: '0};
         min_q   <= '{default: ONES};
         arg_q   <= '{default: '0};
         bnd_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         k_q     <= k_d;
         req_v_q <= req_v_d;
         req_j_q <= req_j_d;
         req_i_q <= req_i_d;
         cnt_q   <= cnt_d;
         ph_q    <= ph_d;
         tk_q    <= tk_d;
         tb_q    <= tb_d;
         idx_q   <= idx_d;
         bv_q    <= bv_d;
         bd_q    <= bd_d;
         bl_q    <= bl_d;
         cost_q  <= cost_d;
         pv_q    <= pv_d;
         pj_q    <= pj_d;
         min_q   <= min_d;
         arg_q   <= arg_d;
         bnd_q   <= bnd_d;
      end
   end

   // F/B RAMs: whole column written at row end, all k read at one shared address
   always_ff @(posedge clk_in) begin
      for (int m = 0; m < MAX_SEG; m++) begin
         if (state_q == StWrite) begin
            f_mem[m][req_i_q] <= min_q[m];
            b_mem[m][req_i_q] <= arg_q[m];
         end
         rd_f_q[m] <= f_mem[m][rd_addr];
         rd_b_q[m] <= b_mem[m][rd_addr];
      end
   end

   assign e_req_valid = req_v_q;
   assign e_req_j     = req_j_q;
   assign e_req_i     = req_i_q;
   assign busy        = busy_q;
   assign bound_valid = bv_q;
   assign bound_data  = bd_q;
   assign bound_last  = bl_q;
   assign cost_out    = cost_q;
   assign done        = done_q;

endmodule

// File: tb/tb_formant_segment_dp.sv
// Self-checking bench for formant_segment_dp: E-source model, beat scoreboard, scenario tasks.
module tb_formant_segment_dp;

   localparam int BW       = 32;
   localparam int NI       = 160;
   localparam int MS       = 8;
   localparam int EL       = 2;
   localparam int IW       = 8;
   localparam int KW       = 4;
   localparam int NREQ     = NI * (NI + 1) / 2;
   localparam int LAT_MAX  = NREQ + NI * (EL + 3) + 2 * MS + 4;
   localparam int WAIT_MAX = 15000;

   typedef struct packed {
      logic [IW-1:0] d;
      logic          l;
      logic          care;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_in, start_in, bound_ready;
   logic [KW-1:0] num_seg_in;
   logic          e_req_valid, busy, bound_valid, bound_last, done;
   logic [IW-1:0] e_req_j, e_req_i, bound_data;
   logic [BW-1:0] e_resp_data, cost_out;

   int    errors = 0;
   int    checks = 0;
   int    mode   = 0;
   int    req_cnt = 0;
   beat_t exp_q[$];
   beat_t mon_b;

   logic          hv [EL];
   logic [IW-1:0] hj [EL];
   logic [IW-1:0] hi [EL];

   always #5 clk = ~clk;

   formant_segment_dp #(
      .BIT_WIDTH(BW),
      .I(NI),
      .MAX_SEG(MS),
      .E_LAT(EL)
   ) dut (
      .clk_in(clk),
      .rst_in(rst_in),
      .start_in(start_in),
      .num_seg_in(num_seg_in),
      .e_req_valid(e_req_valid),
      .e_req_j(e_req_j),
      .e_req_i(e_req_i),
      .e_resp_data(e_resp_data),
      .busy(busy),
      .bound_valid(bound_valid),
      .bound_ready(bound_ready),
      .bound_data(bound_data),
      .bound_last(bound_last),
      .cost_out(cost_out),
      .done(done)
   );

   function automatic int blk(input int x);
      if (x < 50) return 0;
      if (x < 100) return 1;
      return 2;
   endfunction

   function automatic logic [BW-1:0] e_val(input int m, input int j, input int i);
      case (m)
         0: return (j == 0) ? 32'd5 : 32'd7;
         1: return (blk(j) == blk(i)) ? 32'd0 : 32'd10;
         2: return 32'd1;
         default: return 32'hFFFF_FFF0;
      endcase
   endfunction

   // Fixed-latency E source: response appears EL cycles after the request cycle
   always @(posedge clk) begin
      #1;
      if (hv[EL-1]) e_resp_data = e_val(mode, int'(hj[EL-1]), int'(hi[EL-1]));
      else e_resp_data = 32'hDEAD_BEEF;
      for (int n = EL - 1; n > 0; n--) begin
         hv[n] = hv[n-1];
         hj[n] = hj[n-1];
         hi[n] = hi[n-1];
      end
      hv[0] = e_req_valid;
      hj[0] = e_req_j;
      hi[0] = e_req_i;
      if (e_req_valid) req_cnt++;
   end

   // Scoreboard: every accepted beat is matched against the next expected one
   always @(posedge clk) begin
      if (rst_in === 1'b1 && bound_valid === 1'b1 && bound_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_extra: got data=%0d last=%0b, required no beat", bound_data,
                     bound_last);
         end else begin
            mon_b = exp_q.pop_front();
            if ((mon_b.care && bound_data !== mon_b.d) || bound_last !== mon_b.l) begin
               errors++;
               $display("FAIL beat: got data=%0d last=%0b, required data=%0d last=%0b",
                        bound_data, bound_last, mon_b.d, mon_b.l);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int d, input bit l, input bit care);
      beat_t b;
      b.d    = IW'(d);
      b.l    = l;
      b.care = care;
      exp_q.push_back(b);
   endtask

   task automatic start_run(input int k);
      num_seg_in = KW'(k);
      req_cnt    = 0;
      start_in   = 1'b1;
      tick();
      start_in   = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (bound_valid !== 1'b1 && lat < WAIT_MAX) begin
         tick();
         lat++;
      end
   endtask

   task automatic wait_done(output bit seen);
      int cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 400) begin
         if (done === 1'b1) seen = 1'b1;
         else begin
            bound_ready = 1'b1;
            tick();
            cyc++;
         end
      end
      bound_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_in      = 1'b0;
      start_in    = 1'b0;
      bound_ready = 1'b0;
      num_seg_in  = '0;
      repeat (3) tick();
      checks++;
      if ({busy, e_req_valid, bound_valid, bound_last, done, bound_data, e_req_j, e_req_i,
           cost_out} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%0b req=%0b bv=%0b bl=%0b done=%0b bd=%0d j=%0d i=%0d cost=%0h, required all 0",
                  busy, e_req_valid, bound_valid, bound_last, done, bound_data, e_req_j,
                  e_req_i, cost_out);
      end
      rst_in = 1'b1;
      tick();
   endtask

   task automatic test_stall_k3();
      int lat, n, cyc;
      bit seen, held, r;
      logic [IW-1:0] held_d;
      logic held_l;
      mode = 1;
      push(49, 0, 1);
      push(99, 0, 1);
      push(159, 1, 1);
      start_run(3);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL k3_busy: got %0b, required 1", busy);
      end
      wait_valid(lat);
      checks++;
      if (bound_valid !== 1'b1 || lat > LAT_MAX) begin
         errors++;
         $display("FAIL k3_latency: got %0d cycles, required <= %0d", lat, LAT_MAX);
      end
      checks++;
      if (cost_out !== 32'd0) begin
         errors++;
         $display("FAIL k3_cost: got %0h, required 0", cost_out);
      end
      n = 0;
      cyc = 0;
      seen = 1'b0;
      held = 1'b0;
      held_d = '0;
      held_l = 1'b0;
      while (!seen && cyc < 400) begin
         if (done === 1'b1) seen = 1'b1;
         else begin
            if (held) begin
               checks++;
               if (bound_valid !== 1'b1 || bound_data !== held_d || bound_last !== held_l) begin
                  errors++;
                  $display("FAIL k3_stall_hold: got valid=%0b data=%0d last=%0b, required valid=1 data=%0d last=%0b",
                           bound_valid, bound_data, bound_last, held_d, held_l);
               end
            end
            r = (n < 10) ? 1'b0 : (((n - 10) % 2) == 0);
            bound_ready = r;
            held   = (bound_valid === 1'b1) && !r;
            held_d = bound_data;
            held_l = bound_last;
            n++;
            tick();
            cyc++;
         end
      end
      bound_ready = 1'b0;
      checks++;
      if (!seen || exp_q.size() != 0) begin
         errors++;
         $display("FAIL k3_done: got done_seen=%0b beats_left=%0d, required 1 and 0", seen,
                  exp_q.size());
      end
      exp_q.delete();
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL k3_idle_after: got done=%0b busy=%0b, required 0 0", done, busy);
      end
      checks++;
      if (req_cnt != NREQ) begin
         errors++;
         $display("FAIL k3_req_count: got %0d, required %0d", req_cnt, NREQ);
      end
   endtask

   task automatic test_tie_k2();
      int lat;
      bit seen;
      mode = 2;
      push(0, 0, 1);
      push(159, 1, 1);
      start_run(2);
      wait_valid(lat);
      checks++;
      if (cost_out !== 32'd2) begin
         errors++;
         $display("FAIL k2_tie_cost: got %0h, required 2", cost_out);
      end
      wait_done(seen);
      checks++;
      if (!seen || exp_q.size() != 0) begin
         errors++;
         $display("FAIL k2_done: got done_seen=%0b beats_left=%0d, required 1 and 0", seen,
                  exp_q.size());
      end
      exp_q.delete();
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL k2_idle_after: got done=%0b busy=%0b, required 0 0", done, busy);
      end
   endtask

   task automatic test_saturate_k4();
      int lat;
      bit seen;
      mode = 3;
      push(0, 0, 0);
      push(0, 0, 0);
      push(0, 0, 0);
      push(159, 1, 1);
      start_run(4);
      wait_valid(lat);
      checks++;
      if (cost_out !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL k4_sat_cost: got %0h, required ffffffff", cost_out);
      end
      wait_done(seen);
      checks++;
      if (!seen || exp_q.size() != 0) begin
         errors++;
         $display("FAIL k4_done: got done_seen=%0b beats_left=%0d, required 1 and 0", seen,
                  exp_q.size());
      end
      exp_q.delete();
      tick();
      checks++;
      if (req_cnt != NREQ) begin
         errors++;
         $display("FAIL k4_req_count: got %0d, required %0d", req_cnt, NREQ);
      end
   endtask

   task automatic test_reset_midfill_k0();
      int lat, c;
      bit seen;
      mode = 1;
      start_run(3);
      c = 0;
      while (!(e_req_valid === 1'b1 && e_req_i == 8'd40) && c < 3000) begin
         tick();
         c++;
      end
      checks++;
      if (!(e_req_valid === 1'b1 && e_req_i == 8'd40)) begin
         errors++;
         $display("FAIL midfill_reach: got i=%0d valid=%0b, required i=40 valid=1", e_req_i,
                  e_req_valid);
      end
      rst_in = 1'b0;
      tick();
      checks++;
      if ({busy, e_req_valid, bound_valid, bound_last, done, bound_data, e_req_j, e_req_i,
           cost_out} !== '0) begin
         errors++;
         $display("FAIL midfill_reset_outputs: got busy=%0b req=%0b bv=%0b j=%0d i=%0d cost=%0h, required all 0",
                  busy, e_req_valid, bound_valid, e_req_j, e_req_i, cost_out);
      end
      rst_in = 1'b1;
      tick();
      mode = 0;
      push(159, 1, 1);
      start_run(0);
      repeat (5) tick();
      num_seg_in = KW'(3);
      start_in   = 1'b1;
      tick();
      start_in   = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL k0_busy: got %0b, required 1", busy);
      end
      wait_valid(lat);
      checks++;
      if (bound_valid !== 1'b1 || lat > LAT_MAX) begin
         errors++;
         $display("FAIL k0_latency: got %0d cycles, required <= %0d", lat, LAT_MAX);
      end
      checks++;
      if (cost_out !== 32'd5) begin
         errors++;
         $display("FAIL k0_cost: got %0h, required 5", cost_out);
      end
      wait_done(seen);
      checks++;
      if (!seen || exp_q.size() != 0) begin
         errors++;
         $display("FAIL k0_done: got done_seen=%0b beats_left=%0d, required 1 and 0", seen,
                  exp_q.size());
      end
      exp_q.delete();
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL k0_idle_after: got done=%0b busy=%0b, required 0 0", done, busy);
      end
      checks++;
      if (req_cnt != NREQ) begin
         errors++;
         $display("FAIL k0_req_count: got %0d, required %0d", req_cnt, NREQ);
      end
   endtask

   task automatic test_clamp_k9();
      int lat;
      bit seen;
      mode = 2;
      for (int b = 0; b < 7; b++) push(b, 0, 1);
      push(159, 1, 1);
      start_run(9);
      wait_valid(lat);
      checks++;
      if (cost_out !== 32'd8) begin
         errors++;
         $display("FAIL k9_clamp_cost: got %0h, required 8", cost_out);
      end
      wait_done(seen);
      checks++;
      if (!seen || exp_q.size() != 0) begin
         errors++;
         $display("FAIL k9_done: got done_seen=%0b beats_left=%0d, required 1 and 0", seen,
                  exp_q.size());
      end
      exp_q.delete();
      tick();
   endtask

   initial begin
      rst_in      = 1'b0;
      start_in    = 1'b0;
      bound_ready = 1'b0;
      num_seg_in  = '0;
      e_resp_data = '0;
      for (int n = 0; n < EL; n++) begin
         hv[n] = 1'b0;
         hj[n] = '0;
         hi[n] = '0;
      end
      test_reset();
      test_stall_k3();
      test_tie_k2();
      test_saturate_k4();
      test_reset_midfill_k0();
      test_clamp_k9();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/formant_segment_dp.md
Name: formant_segment_dp

Overview:
- Parametrised successor to the fixed five-formant segmentation engine.
- Runs the min-cost spectral segmentation dynamic program for a runtime-selectable segment count K (1..MAX_SEG) over I bins. Segment costs E(j,i) come from an external fixed-latency source.
- After the DP, performs traceback and streams the K segment end boundaries over a valid/ready interface, together with the total cost.
- Sits between the Emin generator and the phi/frequency stage.

Parameters:
- BIT_WIDTH, 32, width of cost values E, F and cost_out.
- I, 160, number of spectral bins; I_WIDTH = $clog2(I).
- MAX_SEG, 8, maximum segment count; requires 1 <= MAX_SEG <= I. K_WIDTH = $clog2(MAX_SEG+1).
- E_LAT, 2, fixed cycles from e_req_valid to its e_resp_data (>= 1).

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous, active-low reset.
- start_in  in  1  pulse; begins a run, accepted only in IDLE.
- num_seg_in  in  K_WIDTH  K, sampled on the accepted start.
- e_req_valid  out  1  request for E(e_req_j, e_req_i).
- e_req_j  out  I_WIDTH  first bin of the segment.
- e_req_i  out  I_WIDTH  last bin of the segment (j <= i).
- e_resp_data  in  BIT_WIDTH  E value, valid exactly E_LAT cycles after its request; no handshake.
- busy  out  1  high from the accepted start until done.
- bound_valid  out  1  boundary beat valid.
- bound_ready  in  1  consumer accepts the beat.
- bound_data  out  I_WIDTH  segment end bin, ascending order.
- bound_last  out  1  marks the K-th beat.
- cost_out  out  BIT_WIDTH  F(K, I-1); valid from the first bound_valid, held until the next start.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rst_in=0): state IDLE. busy, e_req_valid, bound_valid, bound_last and done are 0. bound_data, e_req_j, e_req_i and cost_out are 0. Any in-flight responses are discarded.
- K clamp: num_seg_in of 0 is treated as 1; values above MAX_SEG are treated as MAX_SEG.
- start_in while not IDLE is ignored.
- Recurrence:
  - F(1,i) = E(0,i).
  - For k >= 2: F(k,i) = min over j in [k-1, i] of F(k-1, j-1) + E(j,i). The argmin end of segment k-1 is stored as B(k,i) = j-1.
  - F(k,i) for i < k-1 is the sentinel all-ones.
- Arithmetic: additions saturate at all-ones and never wrap. A sentinel operand gives all-ones.
- Compare and ties: compare is strict less-than, so on ties the smallest j wins.
- Storage: F and B are held in one internal RAM per k, with 1-cycle read. F(k-1, j-1) is read for all k in parallel at the same address.
- FILL: for each i = 0..I-1, issue i+1 back-to-back requests with j = 0..i, one per cycle (e_req_valid high continuously within the row).
- Per-response update: each response updates every k's running min/argmin in parallel.
- DRAIN / WRITE: after the row's last request, wait E_LAT+1 cycles for the final compare, then write F(k,i) and B(k,i) for all k in one cycle. Then advance i, returning to FILL, or go to TRACE after i = I-1.
- Request counts: exactly I(I+1)/2 requests per run (12880 for I=160). No requests outside FILL. Only rows i < K-1 produce sentinels; their requests are still issued.
- TRACE:
  - b_K = I-1; for k = K down to 2, b_{k-1} = B(k, b_k). One k per 2 cycles (RAM read plus register).
  - cost_out is latched from F(K, I-1).
- OUT:
  - Present b_1..b_K in order.
  - Beats transfer on bound_valid & bound_ready.
  - While ready is low, bound_data and bound_last are held stable.
  - bound_last is high only on beat K.
- Completion: after beat K transfers, done pulses for 1 cycle and the next cycle is IDLE with busy low.
- Latency: from start accept to first bound_valid is at most I(I+1)/2 + I*(E_LAT+3) + 2*MAX_SEG + 4 cycles.
- States: IDLE -> FILL -> DRAIN -> WRITE -> (FILL | TRACE) -> OUT -> IDLE.

Test Plan:
- K=1, E(0,i)=5 for all i, other E=7 -> one beat: bound_data=159, bound_last=1, cost_out=5, done pulses; e_req count = 12880.
- K=3, E(j,i)=0 when [j,i] lies within one of {[0,49],[50,99],[100,159]}, else 10 -> beats 49, 99, 159, with last on 159; cost_out=0.
- K=2, all E=1 (tie) -> beats 0, 159; cost_out=2 (smallest j wins).
- K=3 from the second scenario, bound_ready held low for 10 cycles after the first valid, then toggled every cycle -> bound_data stable while stalled; exactly 3 beats with no drop or duplicate.
- All E = 0xFFFFFFF0, K=4 -> cost_out=0xFFFFFFFF (saturated, no wrap).
- rst_in=0 mid-FILL (i=40), then start with num_seg_in=0 -> all outputs are at reset values the cycle after reset; the new run behaves as K=1 and produces the same result as the first scenario. A second start pulse during busy is ignored.
